// File: rtl/stream_mux_rr_if.sv
// Handshake bundle for the N:1 round-robin stream mux.
// The master side drives the channel beats and out_ready; the slave side is the mux.
interface stream_mux_rr_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
);
  localparam int SEL_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_last;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_last;
  logic [SEL_W-1:0]         out_sel;
  logic                     out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_sel
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_sel
  );
endinterface

// File: rtl/stream_mux_rr.sv
// N:1 stream mux with round-robin arbitration and packet lock; 1 clk input handshake to out_valid.
// A stalled output register (out_valid && !out_ready) drops all in_ready and freezes arbitration.
module stream_mux_rr #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  stream_mux_rr_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_CH);

  typedef enum logic {ARB, LOCK} state_t;

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [SEL_W-1:0]   lock_ch, lock_ch_nxt;
  logic [SEL_W-1:0]   arb_grant, grant, idx;
  logic               arb_found;
  logic               ld, xfer;
  logic [NUM_CH-1:0]  ready;

  logic               out_valid_q;
  logic [DATA_W-1:0]  out_data_q;
  logic               out_last_q;
  logic [SEL_W-1:0]   out_sel_q;

  // Search starts just after the last packet's owner; modulo wrap comes free from SEL_W bits.
  always_comb begin
    arb_found = 1'b0;
    arb_grant = '0;
    idx       = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = rr_ptr + SEL_W'(k);
      if (!arb_found && bus.in_valid[idx]) begin
        arb_grant = idx;
        arb_found = 1'b1;
      end
    end
  end

  assign ld    = !out_valid_q || bus.out_ready;
  assign grant = (state == LOCK) ? lock_ch : arb_grant;

  always_comb begin
    ready = '0;
    if (ld && (state == LOCK || bus.in_valid[grant])) begin
      ready[grant] = 1'b1;
    end
  end

  assign xfer         = bus.in_valid[grant] && ready[grant];
  assign bus.in_ready = ready;

  always_comb begin
    state_nxt   = state;
    rr_ptr_nxt  = rr_ptr;
    lock_ch_nxt = lock_ch;
    if (xfer) begin
      case (state)
        ARB: begin
          if (bus.in_last[grant]) begin
            rr_ptr_nxt = grant;
          end else begin
            state_nxt   = LOCK;
            lock_ch_nxt = grant;
          end
        end
        LOCK: begin
          if (bus.in_last[lock_ch]) begin
            state_nxt  = ARB;
            rr_ptr_nxt = lock_ch;
          end
        end
        default: state_nxt = ARB;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB;
      rr_ptr  <= SEL_W'(NUM_CH - 1);
      lock_ch <= '0;
    end else begin
      state   <= state_nxt;
      rr_ptr  <= rr_ptr_nxt;
      lock_ch <= lock_ch_nxt;
    end
  end

  // Data/last/sel keep their old values across bubbles; only out_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else if (ld) begin
      out_valid_q <= xfer;
      if (xfer) begin
        out_data_q <= bus.in_data[int'(grant) * DATA_W +: DATA_W];
        out_last_q <= bus.in_last[grant];
        out_sel_q  <= grant;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sel   = out_sel_q;
endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- N:1 registered stream multiplexer with round-robin arbitration and packet lock. It is the gathering counterpart of the team's 1:N demux blocks.
- Each of NUM_CH input channels presents valid/data/last. The block selects one channel and forwards its beats through a single output register, tagged with the source channel index.
- A channel that starts a packet keeps the grant until its last beat has transferred.

Parameters:
NUM_CH, 4, number of input channels; power of two, 2..8
DATA_W, 8, data width per channel
SEL_W, $clog2(NUM_CH), width of channel index (derived; do not override)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  NUM_CH  per-channel beat valid
in_data  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
in_last  in  NUM_CH  per-channel end-of-packet flag
in_ready  out  NUM_CH  per-channel accept; one-hot or zero
out_valid  out  1  output beat valid (registered)
out_data  out  DATA_W  output beat data (registered)
out_last  out  1  output end-of-packet (registered)
out_sel  out  SEL_W  source channel of the current output beat (registered)
out_ready  in  1  downstream accept

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_last=0, out_sel=0, state=ARB, rr_ptr=NUM_CH-1, lock_ch=0. Channel 0 therefore has first priority after reset.
- Load enable: ld = !out_valid || out_ready. Full throughput is one beat per clock when out_ready stays high.
- Grant g:
  - In ARB, g is the first i with in_valid[i]=1, searching rr_ptr+1, rr_ptr+2, ... modulo NUM_CH.
  - In LOCK, g = lock_ch.
- in_ready[i] = ld && (i==g) && (state==LOCK || in_valid[i]). It is combinational and may depend on in_valid. At most one bit is high.
- Transfer: xfer = in_valid[g] && in_ready[g]. On xfer the output register loads in_data[g], in_last[g] and out_sel=g, and sets out_valid=1. Latency is 1 clk from input handshake to out_valid.
- If ld && !xfer: out_valid goes to 0. Data, last and sel hold their previous values.
- If out_valid && !out_ready: all output registers hold, in_ready is all-zero, and no state changes.
- FSM:
  - ARB, xfer with in_last[g]=0: go to LOCK, lock_ch=g.
  - ARB, xfer with in_last[g]=1 (single-beat packet): stay in ARB, rr_ptr=g.
  - LOCK, xfer with in_last[lock_ch]=1: go to ARB, rr_ptr=lock_ch.
  - LOCK, xfer with in_last=0: stay in LOCK.
- While in LOCK, in_valid from other channels is ignored; no preemption. A gap (in_valid[lock_ch]=0) keeps the lock.
- rr_ptr updates only at packet end. Fairness: a channel that completes a packet has lowest priority in the next arbitration.
- No valid inputs in ARB: in_ready is all-zero and state is unchanged.
- Simultaneous out_ready and new xfer: the old beat leaves and the new beat loads in the same edge, with no bubble.
- Reset mid-packet: the lock is dropped, the output is cleared, and priority returns to channel 0. Upstream is responsible for packet recovery.
- Unknown/X in_valid is not handled. in_data from non-granted channels never reaches the output.

Test Plan:
1. Reset, out_ready=1, ch2 single beat data=0xA5 last=1 → in_ready=4'b0100 in the same cycle; next cycle out_valid=1, out_data=0xA5, out_sel=2, out_last=1; following cycle out_valid=0.
2. All four channels valid with single-beat packets (data=0x10+i), out_ready=1 → out_sel sequence 0,1,2,3,0, one beat per clock, no bubbles.
3. ch1 3-beat packet (0x11,0x12,0x13 last) while ch0 and ch3 are valid throughout → output 0x11,0x12,0x13 with out_sel=1 and no interleaving; next grant is ch3, then ch0.
4. Backpressure: out_ready=0 for 3 cycles with out_valid=1, data=0x55 → out_data stays 0x55, in_ready=0; out_ready=1 with ch0 valid 0x66 → 0x55 accepted and 0x66 loaded on the same edge.
5. Locked gap: ch2 beat 0x21 (last=0), then in_valid[2]=0 for 2 cycles while ch0 is valid → in_ready[0] stays 0; ch2 0x22 last=1 follows, then ch0 is granted.
6. Assert rst_n=0 mid-packet on ch1 → outputs clear asynchronously; after release, with ch0 and ch1 both valid, ch0 is granted first.
